// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker slice.
// Contents:
//   PRBS_W          shift register width (8)
//   TAP_*           feedback tap positions (7,5,4,3) for x^8+x^6+x^5+x^4+1
//   state_e         checker FSM encoding (HUNT=0, VERIFY=1, LOCKED=2)
//   prbs_fb()       feedback function shared by checker and generator models
package prbs_checker_pkg;

  localparam int unsigned PRBS_W = 8;

  localparam int unsigned TAP_0 = 7;
  localparam int unsigned TAP_1 = 5;
  localparam int unsigned TAP_2 = 4;
  localparam int unsigned TAP_3 = 3;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic prbs_fb(input logic [PRBS_W-1:0] s);
    return s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
  endfunction

endpackage

// File: rtl/prbs_next_bit.sv
// Combinational PRBS feedback: given the current 8-bit register contents,
// produce the next bit the generator will transmit.
// Ports:
//   state_i  in  PRBS_W  current shift register contents
//   fb_o     out 1       feedback / next transmitted bit
module prbs_next_bit
  import prbs_checker_pkg::*;
(
  input  logic [PRBS_W-1:0] state_i,
  output logic              fb_o
);

  assign fb_o = prbs_fb(state_i);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 8-bit PRBS generator stream.
// Hunts for a non-zero seed, verifies SYNC_LEN consecutive correct bits,
// then tracks the stream locally and counts mismatches; too many mismatches
// within one WIN_LEN window drops lock.
// Ports:
//   clk        in  1      system clock, rising edge
//   clr        in  1      asynchronous active-low reset
//   bit_in     in  1      received serial bit
//   bit_valid  in  1      qualifies bit_in; state advances only when high
//   cnt_clear  in  1      synchronous clear of err_cnt (wins over increment)
//   locked     out 1      high while in LOCKED
//   err_pulse  out 1      one-cycle pulse on a LOCKED mismatch
//   err_cnt    out ERR_W  saturating LOCKED mismatch count
//   state      out 2      FSM state (HUNT=0, VERIFY=1, LOCKED=2)
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int unsigned SYNC_LEN    = 16,
  parameter int unsigned WIN_LEN     = 64,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             cnt_clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam int unsigned GOOD_W = $clog2(SYNC_LEN + 1);
  localparam int unsigned WCNT_W = $clog2(WIN_LEN + 1);
  localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);

  // Counter values on the bit that completes the respective count.
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(SYNC_LEN - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN_LEN - 1);
  localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(LOSS_THRESH - 1);

  state_e             state_q;
  logic [PRBS_W-1:0]  r_q;
  logic [PRBS_W-1:0]  r_d;
  logic [2:0]         fill_q;
  logic [GOOD_W-1:0]  good_q;
  logic [WCNT_W-1:0]  win_cnt_q;
  logic [WERR_W-1:0]  win_err_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic               locked_q;
  logic               err_pulse_q;

  logic exp_bit;
  logic mismatch;

  prbs_next_bit u_next_bit (
    .state_i (r_q),
    .fb_o    (exp_bit)
  );

  assign mismatch = bit_in ^ exp_bit;

  // While locked, shift in the expected bit so a corrupted received bit
  // cannot poison the following predictions.
  always_comb begin
    r_d = {r_q[PRBS_W-2:0], bit_in};
    if (state_q == ST_LOCKED) begin
      r_d = {r_q[PRBS_W-2:0], exp_bit};
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_HUNT;
      r_q         <= '0;
      fill_q      <= '0;
      good_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bit_valid) begin
        r_q <= r_d;
        case (state_q)
          ST_HUNT: begin
            if (fill_q == 3'd7) begin
              fill_q <= '0;
              // All-zero is the generator's lock-up value: keep hunting.
              if (r_d != '0) begin
                state_q <= ST_VERIFY;
                good_q  <= '0;
              end
            end else begin
              fill_q <= fill_q + 3'd1;
            end
          end
          ST_VERIFY: begin
            if (!mismatch) begin
              good_q <= good_q + 1'b1;
              if (good_q == GOOD_LAST) begin
                state_q   <= ST_LOCKED;
                locked_q  <= 1'b1;
                win_cnt_q <= '0;
                win_err_q <= '0;
              end
            end else begin
              good_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
              end
            end
            // Loss of lock takes priority over the window rollover.
            if (mismatch && (win_err_q == WERR_LAST)) begin
              state_q   <= ST_HUNT;
              locked_q  <= 1'b0;
              fill_q    <= '0;
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else if (win_cnt_q == WCNT_LAST) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              win_err_q <= win_err_q + WERR_W'(mismatch);
            end
          end
          default: begin
            state_q  <= ST_HUNT;
            locked_q <= 1'b0;
            fill_q   <= '0;
          end
        endcase
      end
      if (cnt_clear) begin
        err_cnt_q <= '0;
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

  localparam int unsigned SYNC_LEN    = 16;
  localparam int unsigned WIN_LEN     = 64;
  localparam int unsigned LOSS_THRESH = 4;
  localparam int unsigned ERR_W       = 16;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             cnt_clear = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       state;

  prbs_checker #(
    .SYNC_LEN    (SYNC_LEN),
    .WIN_LEN     (WIN_LEN),
    .LOSS_THRESH (LOSS_THRESH),
    .ERR_W       (ERR_W)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .cnt_clear (cnt_clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transmitter model
  logic [7:0] g_s;

  // Reference checker model (plain integers, driven by the behavioural rules)
  int         m_state;
  int         m_fill;
  int         m_good;
  int         m_wc;
  int         m_we;
  logic [7:0] m_r;
  int         m_err;
  logic       m_pulse;

  task automatic gen_bit(output logic b);
    b   = g_s[7] ^ g_s[5] ^ g_s[4] ^ g_s[3];
    g_s = {g_s[6:0], b};
  endtask

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_good = 0; m_wc = 0; m_we = 0;
    m_r = 8'h00; m_err = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic v, input logic c);
    logic e;
    m_pulse = 1'b0;
    if (v) begin
      e = m_r[7] ^ m_r[5] ^ m_r[4] ^ m_r[3];
      if (m_state == 0) begin
        m_r = {m_r[6:0], b};
        m_fill = m_fill + 1;
        if (m_fill == 8) begin
          m_fill = 0;
          if (m_r != 8'h00) begin m_state = 1; m_good = 0; end
        end
      end else if (m_state == 1) begin
        m_r = {m_r[6:0], b};
        if (b == e) begin
          m_good = m_good + 1;
          if (m_good == SYNC_LEN) begin m_state = 2; m_wc = 0; m_we = 0; end
        end else begin
          m_good = 0;
        end
      end else begin
        m_r = {m_r[6:0], e};
        if (b != e) begin
          m_pulse = 1'b1;
          if (m_err < (1 << ERR_W) - 1) m_err = m_err + 1;
          m_we = m_we + 1;
        end
        m_wc = m_wc + 1;
        if (m_we == LOSS_THRESH) begin
          m_state = 0; m_fill = 0; m_wc = 0; m_we = 0;
        end else if (m_wc == WIN_LEN) begin
          m_wc = 0; m_we = 0;
        end
      end
    end
    if (c) m_err = 0;
  endtask

  function automatic logic [19:0] dut_vec();
    return {state, locked, err_pulse, err_cnt};
  endfunction

  function automatic logic [19:0] model_vec();
    return {2'(m_state), (m_state == 2), m_pulse, 16'(m_err)};
  endfunction

  task automatic step(input logic b, input logic v, input logic c);
    bit_in = b; bit_valid = v; cnt_clear = c;
    @(posedge clk);
    #1;
    model_step(b, v, c);
  endtask

  task automatic clean_bits(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    clr = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; cnt_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    model_reset();
  endtask

  task automatic lock_up();
    do_reset();
    g_s = 8'($urandom_range(1, 255));
    clean_bits(24);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_values: got %h want %h", dut_vec(), 20'h0);
    end
    do_reset();
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL reset_release: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_clean_lock();
    logic b;
    do_reset();
    g_s = 8'h01;
    for (int i = 1; i <= 500; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL clean_model bit %0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (i == 8) begin
        n_checks++;
        if (state !== 2'd1) begin
          n_errors++;
          $display("FAIL clean_verify_at_8: state %0d want 1", state);
        end
      end
      if (i == 23) begin
        n_checks++;
        if (locked !== 1'b0) begin
          n_errors++;
          $display("FAIL clean_unlocked_at_23: locked %b want 0", locked);
        end
      end
      if (i == 24) begin
        n_checks++;
        if (locked !== 1'b1 || state !== 2'd2) begin
          n_errors++;
          $display("FAIL clean_lock_at_24: locked %b state %0d want 1/2", locked, state);
        end
      end
    end
    n_checks++;
    if (err_cnt !== '0) begin
      n_errors++;
      $display("FAIL clean_err_cnt: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_single_error();
    logic b;
    lock_up();
    clean_bits(5);
    gen_bit(b);
    step(~b, 1'b1, 1'b0);
    n_checks++;
    if (err_pulse !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL single_err_hit: pulse %b cnt %0d locked %b want 1/1/1", err_pulse, err_cnt, locked);
    end
    for (int i = 0; i < 100; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
      n_checks++;
      if (err_pulse !== 1'b0 || dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL single_err_followon %0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (err_cnt !== 16'd1 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL single_err_final: cnt %0d locked %b want 1/1", err_cnt, locked);
    end
  endtask

  task automatic test_loss_of_lock();
    logic b;
    lock_up();
    for (int k = 0; k < 4; k++) begin
      clean_bits(4);
      gen_bit(b);
      step(~b, 1'b1, 1'b0);
      n_checks++;
      if (k < 3) begin
        if (locked !== 1'b1 || state !== 2'd2) begin
          n_errors++;
          $display("FAIL loss_early_%0d: locked %b state %0d want 1/2", k, locked, state);
        end
      end else if (locked !== 1'b0 || state !== 2'd0) begin
        n_errors++;
        $display("FAIL loss_fourth: locked %b state %0d want 0/0", locked, state);
      end
    end
    for (int i = 1; i <= 24; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
      if (i == 8 || i == 23 || i == 24) begin
        n_checks++;
        if (locked !== (i == 24) || state !== ((i == 24) ? 2'd2 : 2'd1)) begin
          n_errors++;
          $display("FAIL relock bit %0d: locked %b state %0d", i, locked, state);
        end
      end
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (state !== 2'd0 || locked !== 1'b0 || err_cnt !== '0) begin
        n_errors++;
        $display("FAIL all_zero %0d: state %0d locked %b cnt %0d want 0/0/0", i, state, locked, err_cnt);
      end
    end
  endtask

  task automatic test_gaps();
    logic b;
    logic v;
    int   nvalid = 0;
    int   cyc = 0;
    do_reset();
    g_s = 8'($urandom_range(1, 255));
    while (nvalid < 24 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      if (v) gen_bit(b);
      else b = 1'($urandom_range(0, 1));
      step(b, v, 1'b0);
      cyc++;
      if (v) nvalid++;
      n_checks++;
      if (locked !== (nvalid >= 24) || err_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL gaps valid %0d: locked %b pulse %b", nvalid, locked, err_pulse);
      end
    end
    n_checks++;
    if (nvalid < 24 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL gaps_lock: valid %0d locked %b want 24/1", nvalid, locked);
    end
  endtask

  task automatic test_clear_collision();
    logic b;
    lock_up();
    clean_bits(3);
    gen_bit(b);
    step(~b, 1'b1, 1'b0);
    n_checks++;
    if (err_cnt !== 16'd1) begin
      n_errors++;
      $display("FAIL clear_pre: cnt %0d want 1", err_cnt);
    end
    clean_bits(3);
    gen_bit(b);
    step(~b, 1'b1, 1'b1);
    n_checks++;
    if (err_cnt !== 16'd0 || err_pulse !== 1'b1 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_collision: cnt %0d pulse %b locked %b want 0/1/1", err_cnt, err_pulse, locked);
    end
  endtask

  task automatic test_async_reset();
    logic b;
    lock_up();
    for (int k = 0; k < 3; k++) begin
      clean_bits(3);
      gen_bit(b);
      step(~b, 1'b1, 1'b0);
    end
    n_checks++;
    if (err_cnt !== 16'd3 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL async_pre: cnt %0d locked %b want 3/1", err_cnt, locked);
    end
    #3 clr = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (locked !== 1'b0 || err_cnt !== '0 || state !== 2'd0 || err_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: locked %b cnt %0d state %0d pulse %b want 0/0/0/0", locked, err_cnt, state, err_pulse);
    end
    clr = 1'b1;
  endtask

  task automatic test_random();
    logic b;
    logic v;
    logic c;
    do_reset();
    g_s = 8'($urandom_range(1, 255));
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        gen_bit(b);
        b = b ^ ($urandom_range(0, 39) == 0);
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      c = ($urandom_range(0, 99) == 0);
      step(b, v, c);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL random %0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_all_zero();
    test_gaps();
    test_clear_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial-stream checker for the team's 8-bit pseudo-random generator. It is the receiving end of that generator's bit stream.
- Self-synchronises to an incoming bit stream, verifies it against the generator polynomial, counts bit errors and reports lock status.
- Sits behind a serial link or bus port. Used for link bring-up and for confirming random-source integrity on the FPGA.

Parameters:
- SYNC_LEN, 16: consecutive correct bits required in VERIFY before declaring lock.
- WIN_LEN, 64: length of the error-monitoring window while LOCKED, in valid bits.
- LOSS_THRESH, 4: mismatches within one window that force loss of lock.
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-low reset (clr=0 resets immediately).
- bit_in  in  1  received serial bit.
- bit_valid  in  1  qualifies bit_in; the checker advances only when it is 1.
- cnt_clear  in  1  synchronous clear of err_cnt.
- locked  out  1  high while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse when a mismatch is detected in LOCKED.
- err_cnt  out  ERR_W  saturating count of LOCKED mismatches.
- state  out  2  FSM state: HUNT=0, VERIFY=1, LOCKED=2.

Behaviour:
- Generator model: 8-bit state s; fb = s[7]^s[5]^s[4]^s[3]; next state = {s[6:0], fb}; the transmitted bit is fb.
  - Polynomial x^8+x^6+x^5+x^4+1, period 255.
- Internal register: 8-bit shift register r; counters fill_cnt (3 bit), good_cnt, win_cnt and win_err.
- Expected bit: exp = r[7]^r[5]^r[4]^r[3]. All register state is evaluated only on cycles with bit_valid=1; other cycles hold all state, and err_pulse=0.
- Reset (clr=0): state=HUNT, r=0, all counters 0, locked=0, err_pulse=0, err_cnt=0.
- HUNT:
  - r <= {r[6:0], bit_in}; fill_cnt increments.
  - On the 8th valid bit: if the new r != 0, go to VERIFY with good_cnt=0.
  - If the new r == 0 (lock-up value), stay in HUNT and restart fill_cnt at 0.
- VERIFY:
  - r <= {r[6:0], bit_in}, i.e. the received bit (self-synchronising).
  - Match: good_cnt increments; when good_cnt reaches SYNC_LEN, go to LOCKED and clear win_cnt and win_err.
  - Mismatch: good_cnt <= 0, stay in VERIFY.
  - err_cnt is not affected in VERIFY.
- LOCKED:
  - r <= {r[6:0], exp}, i.e. the expected bit, so a single error does not propagate.
  - Mismatch: err_pulse=1 for that cycle, err_cnt increments (saturates at all-ones), win_err increments.
  - win_cnt increments; when it reaches WIN_LEN, clear win_cnt and win_err.
  - If win_err reaches LOSS_THRESH, go to HUNT with fill_cnt=0 and r retained.
  - If the window end and the threshold are reached on the same bit, loss of lock wins.
- Latency: all outputs are registered and update on the edge that samples the qualifying bit.
  - From reset with a clean stream, locked rises on the edge that samples valid bit number 8+SYNC_LEN (the 24th).
- cnt_clear=1 clears err_cnt to 0, with priority over a simultaneous increment. It does not affect the FSM.
- Reset asserted mid-operation aborts immediately to the reset values above.

Decomposition:
- Shared package: state encodings HUNT/VERIFY/LOCKED, tap positions (7,5,4,3), register width 8.
- One natural sub-module: prbs_next_bit, a combinational feedback function (8-bit in, 1-bit out). It is reusable by the generator's bench model.

Test Plan:
- Clean lock:
  - Stimulus: generator seeded 0x01 (stream begins 0,0,0,1,1,1,0,...) with bit_valid continuously high.
  - Response: state=VERIFY after 8 bits, locked=1 on the 24th bit, err_cnt=0 after 500 bits.
- Single error:
  - Stimulus: while LOCKED, invert one bit.
  - Response: err_pulse high for exactly 1 cycle, err_cnt=1, locked stays 1, no follow-on errors.
- Loss of lock:
  - Stimulus: while LOCKED, invert 4 bits within 64.
  - Response: on the 4th error state=HUNT and locked=0; relock 24 bits after a clean stream resumes.
- All-zero input:
  - Stimulus: 40 zero bits after reset.
  - Response: state stays HUNT, locked=0, err_cnt=0.
- Gaps and clear:
  - Stimulus: bit_valid toggled 1/0 randomly on a clean stream.
  - Response: lock reached after 24 valid bits.
  - Stimulus: assert cnt_clear on the same cycle as an error.
  - Response: err_cnt=0.
- Async reset:
  - Stimulus: drive clr=0 between clock edges while LOCKED with err_cnt=3.
  - Response: immediately locked=0, err_cnt=0, state=HUNT, with no clock edge required.
